// File: rtl/pc_pkg.sv
// Shared types, constants and helpers for the program-counter sequencer.
package pc_pkg;

    // Control states of the sequencer.
    typedef enum logic [1:0] {
        RUN     = 2'd0,
        HANDLER = 2'd1,
        HALTED  = 2'd2
    } pc_state_t;

    // Cause code recorded when a taken jump lands on a misaligned target.
    localparam int unsigned CAUSE_MISALIGN = 32'd0;

    // Default vectors and alignment for a plain rv32 configuration.
    localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_TRAP_VECTOR  = 32'h0000_0100;
    localparam int unsigned DEFAULT_IALIGN       = 32'd4;

    // True when the two low target bits violate the instruction alignment.
    // With 2-byte alignment only bit 0 matters.
    function automatic logic is_misaligned(input logic [1:0] low_bits,
                                           input int unsigned ialign);
        logic fault_s;
        if (ialign == 32'd2) begin
            fault_s = low_bits[0];
        end else begin
            fault_s = |low_bits;
        end
        return fault_s;
    endfunction

endpackage

// File: rtl/pc_target_calc.sv
// Combinational next-PC datapath: base selection, target sum with the JALR
// bit-0 rule, sequential increment, link/AUIPC value and alignment check.
module pc_target_calc
    import pc_pkg::*;
#(
    parameter int unsigned XLEN   = 32'd32,
    parameter int unsigned IALIGN = DEFAULT_IALIGN
) (
    input  logic [XLEN-1:0] pc,
    input  logic            in_en,
    input  logic            branch_decision,
    input  logic [XLEN-1:0] generated_immediate,
    input  logic            pc_add_write_value,
    input  logic [XLEN-1:0] pc_write_value,
    input  logic            auipc_in,
    output logic [XLEN-1:0] target,
    output logic [XLEN-1:0] seq,
    output logic [XLEN-1:0] pc_add_out,
    output logic            misalign
);

    localparam logic [XLEN-1:0] SEQ_STEP = XLEN'(32'd4);

    logic [XLEN-1:0] base_s;
    logic [XLEN-1:0] sum_s;

    // Compute base, sum, masked target, sequential PC and the misalign flag.
    always_comb begin
        if (pc_add_write_value) begin
            base_s = pc_write_value;
        end else begin
            base_s = pc;
        end

        sum_s  = base_s + generated_immediate;
        target = sum_s;
        // Register-relative jumps drop bit 0 of the computed address.
        if (pc_add_write_value) begin
            target[0] = 1'b0;
        end else begin
            target[0] = sum_s[0];
        end

        seq = pc + SEQ_STEP;

        // AUIPC wants the raw sum, never the masked target.
        if (auipc_in) begin
            pc_add_out = sum_s;
        end else begin
            pc_add_out = seq;
        end

        misalign = in_en & branch_decision & is_misaligned(target[1:0], IALIGN);
    end

endmodule

// File: rtl/pc_sequencer.sv
// Program counter with trap/return state machine, double-fault halt and a
// retired-instruction counter. All architectural outputs are registered
// except pc_add_out, which feeds the writeback mux in the same cycle.
module pc_sequencer
    import pc_pkg::*;
#(
    parameter int unsigned     XLEN         = 32'd32,
    parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(DEFAULT_RESET_VECTOR),
    parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'(DEFAULT_TRAP_VECTOR),
    parameter int unsigned     IALIGN       = DEFAULT_IALIGN,
    parameter int unsigned     CAUSE_W      = 32'd4,
    parameter int unsigned     CNT_W        = 32'd64
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               in_en,
    input  logic               branch_decision,
    input  logic [XLEN-1:0]    generated_immediate,
    input  logic               pc_add_write_value,
    input  logic [XLEN-1:0]    pc_write_value,
    input  logic               auipc_in,
    input  logic               trap_req,
    input  logic [CAUSE_W-1:0] trap_cause,
    input  logic               mret,
    output logic [XLEN-1:0]    pc_out,
    output logic [XLEN-1:0]    pc_add_out,
    output logic [XLEN-1:0]    epc_out,
    output logic [CAUSE_W-1:0] cause_out,
    output logic               in_handler,
    output logic               halted,
    output logic [CNT_W-1:0]   instret
);

    if ((IALIGN != 32'd2) && (IALIGN != 32'd4)) begin : g_bad_ialign
        $error("pc_sequencer: IALIGN must be 2 or 4");
    end

    localparam logic [CNT_W-1:0]   CNT_ONE       = CNT_W'(32'd1);
    localparam logic [CAUSE_W-1:0] MISALIGN_CODE = CAUSE_W'(CAUSE_MISALIGN);

    pc_state_t          state_r;
    pc_state_t          state_nxt_s;
    logic [XLEN-1:0]    pc_r;
    logic [XLEN-1:0]    pc_nxt_s;
    logic [XLEN-1:0]    epc_r;
    logic [XLEN-1:0]    epc_nxt_s;
    logic [CAUSE_W-1:0] cause_r;
    logic [CAUSE_W-1:0] cause_nxt_s;
    logic [CNT_W-1:0]   instret_r;
    logic [CNT_W-1:0]   instret_nxt_s;
    logic               in_handler_r;
    logic               halted_r;
    logic [XLEN-1:0]    target_s;
    logic [XLEN-1:0]    seq_s;
    logic               misalign_s;

    pc_target_calc #(
        .XLEN   (XLEN),
        .IALIGN (IALIGN)
    ) u_calc (
        .pc                  (pc_r),
        .in_en               (in_en),
        .branch_decision     (branch_decision),
        .generated_immediate (generated_immediate),
        .pc_add_write_value  (pc_add_write_value),
        .pc_write_value      (pc_write_value),
        .auipc_in            (auipc_in),
        .target              (target_s),
        .seq                 (seq_s),
        .pc_add_out          (pc_add_out),
        .misalign            (misalign_s)
    );

    // Next-state decision in priority order: trap, misalign, mret, advance, stall.
    always_comb begin
        state_nxt_s   = state_r;
        pc_nxt_s      = pc_r;
        epc_nxt_s     = epc_r;
        cause_nxt_s   = cause_r;
        instret_nxt_s = instret_r;

        case (state_r)
            RUN: begin
                if (trap_req) begin
                    epc_nxt_s   = pc_r;
                    cause_nxt_s = trap_cause;
                    pc_nxt_s    = TRAP_VECTOR;
                    state_nxt_s = HANDLER;
                end else if (misalign_s) begin
                    epc_nxt_s   = pc_r;
                    cause_nxt_s = MISALIGN_CODE;
                    pc_nxt_s    = TRAP_VECTOR;
                    state_nxt_s = HANDLER;
                end else if (in_en) begin
                    if (branch_decision) begin
                        pc_nxt_s = target_s;
                    end else begin
                        pc_nxt_s = seq_s;
                    end
                    instret_nxt_s = instret_r + CNT_ONE;
                end else begin
                    pc_nxt_s = pc_r;
                end
            end
            HANDLER: begin
                // A fault inside the handler freezes the saved context.
                if (trap_req || misalign_s) begin
                    state_nxt_s = HALTED;
                end else if (mret) begin
                    pc_nxt_s      = epc_r;
                    state_nxt_s   = RUN;
                    instret_nxt_s = instret_r + CNT_ONE;
                end else if (in_en) begin
                    if (branch_decision) begin
                        pc_nxt_s = target_s;
                    end else begin
                        pc_nxt_s = seq_s;
                    end
                    instret_nxt_s = instret_r + CNT_ONE;
                end else begin
                    pc_nxt_s = pc_r;
                end
            end
            HALTED: begin
                state_nxt_s = HALTED;
            end
            default: begin
                // Unreachable encoding: park safely until reset.
                state_nxt_s = HALTED;
            end
        endcase
    end

    // State and architectural registers; reset wins over every other input.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r      <= RUN;
            pc_r         <= RESET_VECTOR;
            epc_r        <= '0;
            cause_r      <= '0;
            instret_r    <= '0;
            in_handler_r <= 1'b0;
            halted_r     <= 1'b0;
        end else begin
            state_r      <= state_nxt_s;
            pc_r         <= pc_nxt_s;
            epc_r        <= epc_nxt_s;
            cause_r      <= cause_nxt_s;
            instret_r    <= instret_nxt_s;
            in_handler_r <= (state_nxt_s == HANDLER);
            halted_r     <= (state_nxt_s == HALTED);
        end
    end

    assign pc_out     = pc_r;
    assign epc_out    = epc_r;
    assign cause_out  = cause_r;
    assign instret    = instret_r;
    assign in_handler = in_handler_r;
    assign halted     = halted_r;

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: each scenario queues the state it expects
// after every clock edge, a sampler queues what the DUT shows, and the
// scenario drains both queues and compares them.
module tb_pc_sequencer;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] epc;
        logic [3:0]  cause;
        logic        ih;
        logic        hl;
        logic [63:0] cnt;
    } obs_t;

    logic        clock;
    logic        reset;
    logic        in_en;
    logic        branch_decision;
    logic [31:0] generated_immediate;
    logic        pc_add_write_value;
    logic [31:0] pc_write_value;
    logic        auipc_in;
    logic        trap_req;
    logic [3:0]  trap_cause;
    logic        mret;
    logic [31:0] pc_out;
    logic [31:0] pc_add_out;
    logic [31:0] epc_out;
    logic [3:0]  cause_out;
    logic        in_handler;
    logic        halted;
    logic [63:0] instret;

    // Second instance: 4-bit counter, 2-byte alignment.
    logic        reset2;
    logic        in_en2;
    logic        bd2;
    logic [31:0] imm2;
    logic [31:0] pc_out2;
    logic [31:0] pc_add_out2;
    logic [31:0] epc_out2;
    logic [3:0]  cause_out2;
    logic        in_handler2;
    logic        halted2;
    logic [3:0]  instret2;

    obs_t  exp_q[$];
    obs_t  obs_q[$];
    string name_q[$];
    int    n_cmp  = 0;
    int    n_fail = 0;

    pc_sequencer dut (
        .clock               (clock),
        .reset               (reset),
        .in_en               (in_en),
        .branch_decision     (branch_decision),
        .generated_immediate (generated_immediate),
        .pc_add_write_value  (pc_add_write_value),
        .pc_write_value      (pc_write_value),
        .auipc_in            (auipc_in),
        .trap_req            (trap_req),
        .trap_cause          (trap_cause),
        .mret                (mret),
        .pc_out              (pc_out),
        .pc_add_out          (pc_add_out),
        .epc_out             (epc_out),
        .cause_out           (cause_out),
        .in_handler          (in_handler),
        .halted              (halted),
        .instret             (instret)
    );

    pc_sequencer #(.IALIGN(2), .CNT_W(4)) dut2 (
        .clock               (clock),
        .reset               (reset2),
        .in_en               (in_en2),
        .branch_decision     (bd2),
        .generated_immediate (imm2),
        .pc_add_write_value  (1'b0),
        .pc_write_value      (32'h0000_0000),
        .auipc_in            (1'b0),
        .trap_req            (1'b0),
        .trap_cause          (4'h0),
        .mret                (1'b0),
        .pc_out              (pc_out2),
        .pc_add_out          (pc_add_out2),
        .epc_out             (epc_out2),
        .cause_out           (cause_out2),
        .in_handler          (in_handler2),
        .halted              (halted2),
        .instret             (instret2)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic idle_inputs();
        in_en = 1'b0; branch_decision = 1'b0; generated_immediate = 32'h0;
        pc_add_write_value = 1'b0; pc_write_value = 32'h0; auipc_in = 1'b0;
        trap_req = 1'b0; trap_cause = 4'h0; mret = 1'b0; reset = 1'b0;
    endtask

    task automatic exp_push(input string n, input logic [31:0] pc, input logic [31:0] epc,
                            input logic [3:0] c, input logic ih, input logic hl,
                            input logic [63:0] cnt);
        obs_t e;
        e.pc = pc; e.epc = epc; e.cause = c; e.ih = ih; e.hl = hl; e.cnt = cnt;
        exp_q.push_back(e);
        name_q.push_back(n);
    endtask

    // Advance one clock and record the selected instance's outputs.
    task automatic tick(input bit sel2);
        obs_t o;
        @(posedge clock);
        #1;
        if (sel2) begin
            o.pc = pc_out2; o.epc = epc_out2; o.cause = cause_out2;
            o.ih = in_handler2; o.hl = halted2; o.cnt = {60'd0, instret2};
        end else begin
            o.pc = pc_out; o.epc = epc_out; o.cause = cause_out;
            o.ih = in_handler; o.hl = halted; o.cnt = instret;
        end
        obs_q.push_back(o);
    endtask

    task automatic test_reset();
        obs_t e, o; string n;
        idle_inputs();
        reset = 1'b1; reset2 = 1'b1; in_en = 1'b1; trap_req = 1'b1; trap_cause = 4'h7;
        branch_decision = 1'b1; generated_immediate = 32'h55; mret = 1'b1;
        exp_push("reset_override", 32'h0, 32'h0, 4'h0, 1'b0, 1'b0, 64'd0); tick(1'b0);
        idle_inputs();
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); n = name_q.pop_front(); n_cmp++;
            if (obs_q.size() == 0) begin n_fail++; $display("FAIL %s: no output sampled", n); end
            else begin
                o = obs_q.pop_front();
                if (o !== e) begin
                    n_fail++;
                    $display("FAIL %s: got pc=%h epc=%h cause=%h ih=%b hl=%b cnt=%0d, expected pc=%h epc=%h cause=%h ih=%b hl=%b cnt=%0d",
                             n, o.pc, o.epc, o.cause, o.ih, o.hl, o.cnt, e.pc, e.epc, e.cause, e.ih, e.hl, e.cnt);
                end
            end
        end
    endtask

    task automatic test_sequential();
        obs_t e, o; string n;
        in_en = 1'b1;
        n_cmp++;
        if (pc_add_out !== 32'h4) begin
            n_fail++; $display("FAIL link_at_reset: got %h expected %h", pc_add_out, 32'h4);
        end
        exp_push("seq_1", 32'h4, 32'h0, 4'h0, 1'b0, 1'b0, 64'd1); tick(1'b0);
        exp_push("seq_2", 32'h8, 32'h0, 4'h0, 1'b0, 1'b0, 64'd2); tick(1'b0);
        exp_push("seq_3", 32'hC, 32'h0, 4'h0, 1'b0, 1'b0, 64'd3); tick(1'b0);
        in_en = 1'b0;
        exp_push("stall", 32'hC, 32'h0, 4'h0, 1'b0, 1'b0, 64'd3); tick(1'b0);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); n = name_q.pop_front(); n_cmp++;
            if (obs_q.size() == 0) begin n_fail++; $display("FAIL %s: no output sampled", n); end
            else begin
                o = obs_q.pop_front();
                if (o !== e) begin
                    n_fail++;
                    $display("FAIL %s: got pc=%h epc=%h cause=%h ih=%b hl=%b cnt=%0d, expected pc=%h epc=%h cause=%h ih=%b hl=%b cnt=%0d",
                             n, o.pc, o.epc, o.cause, o.ih, o.hl, o.cnt, e.pc, e.epc, e.cause, e.ih, e.hl, e.cnt);
                end
            end
        end
    endtask

    task automatic test_misalign();
        obs_t e, o; string n;
        in_en = 1'b1;
        exp_push("to_0x10", 32'h10, 32'h0, 4'h0, 1'b0, 1'b0, 64'd4); tick(1'b0);
        branch_decision = 1'b1; generated_immediate = 32'h6;
        exp_push("misalign_trap", 32'h100, 32'h10, 4'h0, 1'b1, 1'b0, 64'd4); tick(1'b0);
        idle_inputs(); mret = 1'b1;
        exp_push("mret_back", 32'h10, 32'h10, 4'h0, 1'b0, 1'b0, 64'd5); tick(1'b0);
        idle_inputs();
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); n = name_q.pop_front(); n_cmp++;
            if (obs_q.size() == 0) begin n_fail++; $display("FAIL %s: no output sampled", n); end
            else begin
                o = obs_q.pop_front();
                if (o !== e) begin
                    n_fail++;
                    $display("FAIL %s: got pc=%h epc=%h cause=%h ih=%b hl=%b cnt=%0d, expected pc=%h epc=%h cause=%h ih=%b hl=%b cnt=%0d",
                             n, o.pc, o.epc, o.cause, o.ih, o.hl, o.cnt, e.pc, e.epc, e.cause, e.ih, e.hl, e.cnt);
                end
            end
        end
    endtask

    task automatic test_jalr();
        obs_t e, o; string n;
        reset = 1'b1;
        exp_push("jalr_reset", 32'h0, 32'h0, 4'h0, 1'b0, 1'b0, 64'd0); tick(1'b0);
        idle_inputs();
        pc_add_write_value = 1'b1; pc_write_value = 32'h2000; generated_immediate = 32'h5; auipc_in = 1'b1;
        #1; n_cmp++;
        if (pc_add_out !== 32'h2005) begin
            n_fail++; $display("FAIL auipc_sum: got %h expected %h", pc_add_out, 32'h2005);
        end
        auipc_in = 1'b0; pc_write_value = 32'h2001; generated_immediate = 32'h3;
        branch_decision = 1'b1; in_en = 1'b1;
        #1; n_cmp++;
        if (pc_add_out !== 32'h4) begin
            n_fail++; $display("FAIL jalr_link: got %h expected %h", pc_add_out, 32'h4);
        end
        exp_push("jalr_2004", 32'h2004, 32'h0, 4'h0, 1'b0, 1'b0, 64'd1); tick(1'b0);
        pc_write_value = 32'h3000; generated_immediate = 32'h1;
        exp_push("jalr_bit0", 32'h3000, 32'h0, 4'h0, 1'b0, 1'b0, 64'd2); tick(1'b0);
        idle_inputs(); mret = 1'b1; in_en = 1'b1;
        exp_push("mret_in_run", 32'h3004, 32'h0, 4'h0, 1'b0, 1'b0, 64'd3); tick(1'b0);
        in_en = 1'b0;
        exp_push("mret_run_stall", 32'h3004, 32'h0, 4'h0, 1'b0, 1'b0, 64'd3); tick(1'b0);
        idle_inputs();
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); n = name_q.pop_front(); n_cmp++;
            if (obs_q.size() == 0) begin n_fail++; $display("FAIL %s: no output sampled", n); end
            else begin
                o = obs_q.pop_front();
                if (o !== e) begin
                    n_fail++;
                    $display("FAIL %s: got pc=%h epc=%h cause=%h ih=%b hl=%b cnt=%0d, expected pc=%h epc=%h cause=%h ih=%b hl=%b cnt=%0d",
                             n, o.pc, o.epc, o.cause, o.ih, o.hl, o.cnt, e.pc, e.epc, e.cause, e.ih, e.hl, e.cnt);
                end
            end
        end
    endtask

    task automatic test_trap_return();
        obs_t e, o; string n;
        reset = 1'b1;
        exp_push("tr_reset", 32'h0, 32'h0, 4'h0, 1'b0, 1'b0, 64'd0); tick(1'b0);
        idle_inputs(); branch_decision = 1'b1; generated_immediate = 32'h40; in_en = 1'b1;
        exp_push("jal_0x40", 32'h40, 32'h0, 4'h0, 1'b0, 1'b0, 64'd1); tick(1'b0);
        idle_inputs(); trap_req = 1'b1; trap_cause = 4'h3;
        exp_push("trap_no_en", 32'h100, 32'h40, 4'h3, 1'b1, 1'b0, 64'd1); tick(1'b0);
        idle_inputs(); in_en = 1'b1;
        exp_push("handler_adv", 32'h104, 32'h40, 4'h3, 1'b1, 1'b0, 64'd2); tick(1'b0);
        idle_inputs(); mret = 1'b1;
        exp_push("mret_0x40", 32'h40, 32'h40, 4'h3, 1'b0, 1'b0, 64'd3); tick(1'b0);
        idle_inputs(); in_en = 1'b1;
        exp_push("to_0x44", 32'h44, 32'h40, 4'h3, 1'b0, 1'b0, 64'd4); tick(1'b0);
        trap_req = 1'b1; trap_cause = 4'hB; mret = 1'b1;
        exp_push("trap_beats_mret", 32'h100, 32'h44, 4'hB, 1'b1, 1'b0, 64'd4); tick(1'b0);
        idle_inputs();
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); n = name_q.pop_front(); n_cmp++;
            if (obs_q.size() == 0) begin n_fail++; $display("FAIL %s: no output sampled", n); end
            else begin
                o = obs_q.pop_front();
                if (o !== e) begin
                    n_fail++;
                    $display("FAIL %s: got pc=%h epc=%h cause=%h ih=%b hl=%b cnt=%0d, expected pc=%h epc=%h cause=%h ih=%b hl=%b cnt=%0d",
                             n, o.pc, o.epc, o.cause, o.ih, o.hl, o.cnt, e.pc, e.epc, e.cause, e.ih, e.hl, e.cnt);
                end
            end
        end
    endtask

    task automatic test_double_fault();
        obs_t e, o; string n;
        trap_req = 1'b1; trap_cause = 4'h5;
        exp_push("double_trap", 32'h100, 32'h44, 4'hB, 1'b0, 1'b1, 64'd4); tick(1'b0);
        for (int i = 0; i < 5; i++) begin
            idle_inputs(); in_en = 1'b1; branch_decision = 1'b1; generated_immediate = 32'h8;
            mret = i[0]; trap_req = i[1];
            exp_push("halted_frozen", 32'h100, 32'h44, 4'hB, 1'b0, 1'b1, 64'd4); tick(1'b0);
        end
        idle_inputs(); reset = 1'b1;
        exp_push("halt_reset", 32'h0, 32'h0, 4'h0, 1'b0, 1'b0, 64'd0); tick(1'b0);
        idle_inputs(); trap_req = 1'b1; trap_cause = 4'h2;
        exp_push("trap_c2", 32'h100, 32'h0, 4'h2, 1'b1, 1'b0, 64'd0); tick(1'b0);
        idle_inputs(); in_en = 1'b1; branch_decision = 1'b1; generated_immediate = 32'h2;
        exp_push("misalign_in_handler", 32'h100, 32'h0, 4'h2, 1'b0, 1'b1, 64'd0); tick(1'b0);
        idle_inputs(); reset = 1'b1;
        exp_push("halt_reset2", 32'h0, 32'h0, 4'h0, 1'b0, 1'b0, 64'd0); tick(1'b0);
        idle_inputs();
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); n = name_q.pop_front(); n_cmp++;
            if (obs_q.size() == 0) begin n_fail++; $display("FAIL %s: no output sampled", n); end
            else begin
                o = obs_q.pop_front();
                if (o !== e) begin
                    n_fail++;
                    $display("FAIL %s: got pc=%h epc=%h cause=%h ih=%b hl=%b cnt=%0d, expected pc=%h epc=%h cause=%h ih=%b hl=%b cnt=%0d",
                             n, o.pc, o.epc, o.cause, o.ih, o.hl, o.cnt, e.pc, e.epc, e.cause, e.ih, e.hl, e.cnt);
                end
            end
        end
    endtask

    task automatic test_pc_wrap();
        obs_t e, o; string n;
        in_en = 1'b1; branch_decision = 1'b1; generated_immediate = 32'hFFFF_FFFC;
        exp_push("jump_top", 32'hFFFF_FFFC, 32'h0, 4'h0, 1'b0, 1'b0, 64'd1); tick(1'b0);
        branch_decision = 1'b0;
        #1; n_cmp++;
        if (pc_add_out !== 32'h0) begin
            n_fail++; $display("FAIL link_wrap: got %h expected %h", pc_add_out, 32'h0);
        end
        exp_push("pc_wrap", 32'h0, 32'h0, 4'h0, 1'b0, 1'b0, 64'd2); tick(1'b0);
        idle_inputs();
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); n = name_q.pop_front(); n_cmp++;
            if (obs_q.size() == 0) begin n_fail++; $display("FAIL %s: no output sampled", n); end
            else begin
                o = obs_q.pop_front();
                if (o !== e) begin
                    n_fail++;
                    $display("FAIL %s: got pc=%h epc=%h cause=%h ih=%b hl=%b cnt=%0d, expected pc=%h epc=%h cause=%h ih=%b hl=%b cnt=%0d",
                             n, o.pc, o.epc, o.cause, o.ih, o.hl, o.cnt, e.pc, e.epc, e.cause, e.ih, e.hl, e.cnt);
                end
            end
        end
    endtask

    task automatic test_counter_wrap();
        obs_t e, o; string n;
        reset2 = 1'b0; in_en2 = 1'b1; bd2 = 1'b0; imm2 = 32'h0;
        for (int i = 1; i <= 16; i++) begin
            exp_push("cnt4_step", 32'(i * 4), 32'h0, 4'h0, 1'b0, 1'b0, 64'(i % 16)); tick(1'b1);
        end
        bd2 = 1'b1; imm2 = 32'h6;
        exp_push("ialign2_ok", 32'h46, 32'h0, 4'h0, 1'b0, 1'b0, 64'd1); tick(1'b1);
        imm2 = 32'h1;
        exp_push("ialign2_odd", 32'h100, 32'h46, 4'h0, 1'b1, 1'b0, 64'd1); tick(1'b1);
        in_en2 = 1'b0; bd2 = 1'b0; imm2 = 32'h0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); n = name_q.pop_front(); n_cmp++;
            if (obs_q.size() == 0) begin n_fail++; $display("FAIL %s: no output sampled", n); end
            else begin
                o = obs_q.pop_front();
                if (o !== e) begin
                    n_fail++;
                    $display("FAIL %s: got pc=%h epc=%h cause=%h ih=%b hl=%b cnt=%0d, expected pc=%h epc=%h cause=%h ih=%b hl=%b cnt=%0d",
                             n, o.pc, o.epc, o.cause, o.ih, o.hl, o.cnt, e.pc, e.epc, e.cause, e.ih, e.hl, e.cnt);
                end
            end
        end
    endtask

    initial begin
        idle_inputs();
        reset2 = 1'b1; in_en2 = 1'b0; bd2 = 1'b0; imm2 = 32'h0;
        test_reset();
        test_sequential();
        test_misalign();
        test_jalr();
        test_trap_return();
        test_double_fault();
        test_pc_wrap();
        test_counter_wrap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Parametrised next-generation program counter for the rv32 core.
- Generalises the single-cycle PC to a configurable width, reset vector and instruction alignment.
- Adds a trap/return state machine, jump-target alignment checking with fault redirect, JALR bit-0 clearing and a retired-instruction counter.
- Sits between decode/branch-compare and instruction fetch; `pc_add_out` feeds the writeback mux (link value / AUIPC result).

Parameters:
- XLEN, 32, datapath and PC width in bits.
- RESET_VECTOR, 0, PC value loaded on reset.
- TRAP_VECTOR, 32'h0000_0100, PC loaded on trap entry.
- IALIGN, 4, instruction alignment in bytes; only 2 or 4 are legal (elaboration error otherwise).
- CAUSE_W, 4, trap cause width.
- CNT_W, 64, retired-instruction counter width.

Ports:
- clock  in  1  system clock, all state on rising edge
- reset  in  1  synchronous, active-high; sampled on rising edge of clock
- in_en  in  1  advance enable; 0 = stall (PC holds)
- branch_decision  in  1  1 = take target (branch/JAL/JALR), 0 = sequential
- generated_immediate  in  XLEN  sign-extended immediate
- pc_add_write_value  in  1  1 = base is pc_write_value (JALR/AUIPC operand), 0 = base is current PC
- pc_write_value  in  XLEN  register base operand
- auipc_in  in  1  selects `pc_add_out` = base+imm instead of PC+4
- trap_req  in  1  external/ecall trap request, taken regardless of in_en
- trap_cause  in  CAUSE_W  cause code captured with trap_req
- mret  in  1  return from handler
- pc_out  out  XLEN  current PC
- pc_add_out  out  XLEN  link value or AUIPC sum (combinational)
- epc_out  out  XLEN  saved exception PC
- cause_out  out  CAUSE_W  saved cause
- in_handler  out  1  state == HANDLER
- halted  out  1  state == HALTED
- instret  out  CNT_W  retired-instruction count

Behaviour:
- **Reset.** Synchronous only: asynchronous assertion has no effect until the next rising edge. On that edge:
  - pc_out = RESET_VECTOR; epc_out = 0; cause_out = 0; instret = 0; state = RUN.
  - in_handler = 0, halted = 0.
  - Reset overrides every other input in the same cycle.
- **Combinational datapath.**
  - base = pc_add_write_value ? pc_write_value : pc.
  - sum = base + imm, modulo 2^XLEN.
  - target = sum with bit 0 cleared when pc_add_write_value = 1 (JALR rule); otherwise target = sum.
  - seq = pc + 4, wraps at 2^XLEN.
  - pc_add_out = auipc_in ? sum (unmasked) : seq. Combinational, zero latency.
- **Misalignment.**
  - misalign = in_en & branch_decision & (target mod IALIGN != 0).
  - With IALIGN = 2, only bit 0 is checked (always 0 for JALR).
- **Priority each edge (highest first):** reset, then HALTED hold, then trap_req, then misalign, then mret, then in_en advance, then stall.
- **State RUN.**
  - trap_req: epc <= pc; cause <= trap_cause; pc <= TRAP_VECTOR; go to HANDLER.
  - misalign: epc <= pc; cause <= 0 (CAUSE_MISALIGN); pc <= TRAP_VECTOR; go to HANDLER; instret not incremented.
  - mret in RUN: ignored, treated as a normal instruction per in_en.
  - in_en: pc <= branch_decision ? target : seq; instret += 1.
  - Stall (in_en = 0): pc holds; instret holds.
- **State HANDLER.**
  - in_en advance: same rules as RUN, including instret += 1.
  - mret (no trap/misalign): pc <= epc; go to RUN; instret += 1.
  - trap_req or misalign: double fault. epc and cause are NOT overwritten; pc holds; go to HALTED.
- **State HALTED.** All state frozen; only reset leaves.
- **Counter.** instret wraps to 0 from all-ones.
- **Simultaneous inputs.**
  - trap_req with mret: trap wins.
  - trap_req with in_en = 0: trap still taken.
- **Outputs.** pc_out, epc_out, cause_out and the flags are registered, valid one cycle after the deciding edge.

Decomposition:
- Package `pc_pkg`:
  - pc_state_t enum {RUN, HANDLER, HALTED}.
  - CAUSE_MISALIGN = 0.
  - Default vector localparams.
- One sub-module, `pc_target_calc`: combinational base/sum/target/seq/misalign. Keeps the FSM file register-only.

Test Plan:
1. Reset then 3 cycles in_en = 1, branch_decision = 0 -> pc_out 0x0, 0x4, 0x8, 0xC; instret = 3.
2. pc = 0x10, branch_decision = 1, imm = 0x6 (IALIGN = 4) -> pc_out = 0x100, epc_out = 0x10, cause_out = 0, in_handler = 1, instret unchanged.
3. JALR: pc_write_value = 0x2001, imm = 0x3, pc_add_write_value = 1, branch_decision = 1 -> pc_out = 0x2004; pc_add_out before edge = old pc + 4.
4. In HANDLER with epc = 0x40, mret = 1 -> pc_out = 0x40, in_handler = 0; then trap_req with cause 0xB at pc = 0x44 -> epc_out = 0x44, cause_out = 0xB.
5. In HANDLER, trap_req = 1 -> halted = 1; 5 cycles of in_en = 1 -> pc and instret unchanged; reset -> pc_out = RESET_VECTOR, halted = 0.
6. Wrap cases:
   - pc = 0xFFFF_FFFC, seq advance -> pc_out = 0x0.
   - instret preloaded via CNT_W = 4 instance at 0xF -> 0x0.
   - in_en = 0 with trap_req = 1 -> trap still taken.
